// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: stage encodings and bit-counter sizing shared by the UART receiver.
package uart_rx_pkg;
    localparam int CTR_W = 11;
    typedef logic [CTR_W-1:0] ctr_t;
    localparam ctr_t BAUD_DEFAULT = 11'd3;
    localparam logic [4:0] STG_IDLE  = 5'd0;
    localparam logic [4:0] STG_START = 5'd1;
    localparam logic [4:0] STG_DATA0 = 5'd2;
    localparam logic [4:0] STG_DATA7 = 5'd9;
    localparam logic [4:0] STG_STOP  = 5'd10;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer plus edge-detect flop for the rx line, all resetting to idle-high.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic meta_q, rx_s_q, rx_d_q;
    logic [2:0] live_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
            live_q <= '0;
        end else begin
            meta_q <= rx;
            rx_s_q <= meta_q;
            rx_d_q <= rx_s_q;
            live_q <= {live_q[1:0], 1'b1};
        end
    end
    // rx_d only counts as high once it holds a real post-reset sample, so a line held low through release is not an edge
    assign rx_s = rx_s_q;
    assign fall = live_q[2] & rx_d_q & ~rx_s_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with valid/ack handshake, framing-error pulse and sticky overrun flag.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter ctr_t BAUD_THRESHOLD = BAUD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             rx_frame_err,
    output logic             rx_overrun,
    output logic [CTR_W-1:0] ctr,
    output logic [4:0]       stage
);
    localparam ctr_t HALF = BAUD_THRESHOLD >> 1;
    logic       rx_s, fall, full;
    logic [4:0] stage_q, stage_d;
    ctr_t       ctr_q, ctr_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

    uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_s(rx_s), .fall(fall));

    assign full = ctr_q == BAUD_THRESHOLD;

    always_comb begin
        stage_d = stage_q;
        ctr_d   = ctr_q + 11'd1;
        shift_d = shift_q;
        data_d  = data_q;
        ferr_d  = 1'b0;
        valid_d = valid_q & ~rx_ack;
        ovr_d   = ovr_q & ~(valid_q & rx_ack);
        if (stage_q == STG_IDLE) begin
            ctr_d = '0;
            if (fall) stage_d = STG_START;
        end else if (stage_q == STG_START) begin
            if (ctr_q == HALF) begin
                ctr_d   = '0;
                stage_d = rx_s ? STG_IDLE : STG_DATA0;
            end
        end else if (stage_q <= STG_DATA7) begin
            if (full) begin
                ctr_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                stage_d = stage_q + 5'd1;
            end
        end else if (stage_q == STG_STOP) begin
            if (full) begin
                ctr_d   = '0;
                stage_d = STG_IDLE;
                if (!rx_s) ferr_d = 1'b1;
                else if (!valid_q || rx_ack) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else ovr_d = 1'b1;
            end
        end else begin
            ctr_d   = '0;
            stage_d = STG_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= STG_IDLE;
            ctr_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            ctr_q   <= ctr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign ctr          = ctr_q;
    assign stage        = stage_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames from a bench line model, checked against a queue of expected bytes.
module tb_uart_rx;
    localparam int B    = 3;
    localparam int HALF = B >> 1;
    localparam int LAT  = 3 + HALF + 1 + 9 * (B + 1);
    localparam int SEND = 10 * (B + 1);

    logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ack = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_frame_err, rx_overrun;
    logic [10:0] ctr;
    logic [4:0]  stage;

    int vectors = 0, miscompares = 0, ferr_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.BAUD_THRESHOLD(11'd3)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .ctr(ctr), .stage(stage)
    );

    always @(negedge clk) if (rx_frame_err) ferr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic line_bit(input logic v);
        rx = v;
        repeat (B + 1) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        rx = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic take(input string tag);
        int n;
        logic [7:0] e;
        wait_valid(n);
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_data"}, 32'(rx_data), 32'(e));
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        int n, f0;
        logic saw;
        logic [7:0] e;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_ferr", 32'(rx_frame_err), 32'd0);
        chk("rst_ovr", 32'(rx_overrun), 32'd0);
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_ctr", 32'(ctr), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        f0 = ferr_cnt;
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1);
        wait_valid(n);
        chk("t1_latency_window", 32'((SEND + n) >= LAT - 1 && (SEND + n) <= LAT + 1), 32'd1);
        e = exp_q.pop_front();
        chk("t1_data", 32'(rx_data), 32'(e));
        chk("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        ack();
        chk("t1_ack_clears", 32'(rx_valid), 32'd0);

        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hA3);
        fork
            begin
                send(8'h0F, 1'b1);
                send(8'hA3, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    take($sformatf("t2_b%0d", k));
                    @(negedge clk);
                    ack();
                end
            end
        join
        chk("t2_ovr", 32'(rx_overrun), 32'd0);
        chk("t2_valid_low", 32'(rx_valid), 32'd0);

        repeat (3) @(negedge clk);
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (stage == 5'd1) saw = 1'b1;
        end
        chk("t3_saw_start", 32'(saw), 32'd1);
        chk("t3_back_idle", 32'(stage), 32'd0);
        chk("t3_no_valid", 32'(rx_valid), 32'd0);
        chk("t3_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        f0 = ferr_cnt;
        send(8'hC3, 1'b0);
        repeat (6) @(negedge clk);
        chk("t4_ferr_one_pulse", 32'(ferr_cnt - f0), 32'd1);
        chk("t4_no_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        take("t4_next");
        ack();

        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_valid", 32'(rx_valid), 32'd1);
        e = exp_q.pop_front();
        chk("t5_first_kept", 32'(rx_data), 32'(e));
        chk("t5_ovr_set", 32'(rx_overrun), 32'd1);
        ack();
        chk("t5_ack_valid", 32'(rx_valid), 32'd0);
        chk("t5_ack_ovr", 32'(rx_overrun), 32'd0);
        exp_q.push_back(8'h33);
        send(8'h33, 1'b1);
        take("t5_held");
        exp_q.push_back(8'h44);
        send(8'h44, 1'b1);
        ack();
        chk("t5_race_valid", 32'(rx_valid), 32'd1);
        e = exp_q.pop_front();
        chk("t5_race_data", 32'(rx_data), 32'(e));
        chk("t5_race_ovr", 32'(rx_overrun), 32'd0);

        rx = 1'b0;
        n = 0;
        while (stage != 5'd6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_at_bit4", 32'(stage), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(rx_valid), 32'd0);
        chk("t6_async_data", 32'(rx_data), 32'd0);
        chk("t6_async_ferr", 32'(rx_frame_err), 32'd0);
        chk("t6_async_ovr", 32'(rx_overrun), 32'd0);
        chk("t6_async_stage", 32'(stage), 32'd0);
        chk("t6_async_ctr", 32'(ctr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (stage != 5'd0) saw = 1'b1;
        end
        chk("t6_no_false_start", 32'(saw), 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1);
        take("t6_after");
        ack();
        chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
